// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: beat sequencer for a 4-lane vector unit.
// An accepted op is split into 1..4 beats of up to four elements each.
// Each issued beat is echoed on the writeback strobe two cycles later.
// The op completes when the final beat reaches writeback.
module vec_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] vlen,
  input  logic [3:0] wa3,
  input  logic       hold,
  input  logic       flush,
  output logic       busy,
  output logic       alu_en,
  output logic [1:0] beat_idx,
  output logic [3:0] lane_mask,
  output logic       wb_en,
  output logic [1:0] wb_beat,
  output logic [3:0] wb_mask,
  output logic       done,
  output logic       pend_valid,
  output logic [3:0] pend_wa3
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // Latched operation parameters and beat counter
  logic [1:0] r_cnt;       // index of the next beat to issue
  logic [1:0] r_last_idx;  // index of the final beat (B-1)
  logic [1:0] r_rem;       // vlen_eff mod 4, shapes the final-beat mask
  logic [3:0] r_wa3;       // destination register of the op in flight

  // Two-stage writeback pipe; stage 2 drives the wb_* outputs
  logic       r_p1_en;
  logic [1:0] r_p1_beat;
  logic [3:0] r_p1_mask;
  logic       r_p1_last;
  logic       r_p2_en;
  logic [1:0] r_p2_beat;
  logic [3:0] r_p2_mask;
  logic       r_p2_last;

  logic [4:0] w_vlen_eff;
  logic [1:0] w_last_idx;
  logic       w_accept;
  logic       w_issue;
  logic       w_last_beat;
  logic       w_final_issue;
  logic [3:0] w_mask_raw;
  logic       w_wb_fire;
  logic       w_done;

  // Clamp the element count to the 16 elements four beats can carry
  assign w_vlen_eff = (vlen > 5'd16) ? 5'd16 : vlen;

  // Final beat index = (vlen_eff-1)/4; meaningful only when vlen != 0
  assign w_last_idx = 2'((w_vlen_eff - 5'd1) >> 2);

  // A new op is taken only from IDLE, with a non-empty vector and no flush
  assign w_accept = (r_state == S_IDLE) && start && (vlen != 5'd0) && !flush;

  // A beat issues when the FSM is issuing and neither stalled nor aborted
  assign w_issue       = (r_state == S_ISSUE) && !hold && !flush;
  assign w_last_beat   = (r_cnt == r_last_idx);
  assign w_final_issue = w_issue && w_last_beat;

  // Writeback fires from pipe stage 2 unless a flush is under way
  assign w_wb_fire = r_p2_en && !flush;
  assign w_done    = w_wb_fire && r_p2_last;

  // Lane mask: full except on the final beat, where the remainder trims it
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    w_mask_raw = 4'b1111;
    if (w_last_beat) begin
      case (r_rem)
        2'd1:    w_mask_raw = 4'b0001;
        2'd2:    w_mask_raw = 4'b0011;
        2'd3:    w_mask_raw = 4'b0111;
        default: w_mask_raw = 4'b1111;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept)      w_state_nxt = S_ISSUE;
        S_ISSUE: if (w_final_issue) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_done)        w_state_nxt = S_IDLE;
        default:                    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode; beat fields are zero whenever no beat is issuing
  always_comb begin
    busy       = (r_state != S_IDLE);
    alu_en     = w_issue;
    beat_idx   = 2'd0;
    lane_mask  = 4'd0;
    wb_en      = w_wb_fire;
    wb_beat    = 2'd0;
    wb_mask    = 4'd0;
    done       = w_done;
    pend_valid = busy;
    pend_wa3   = 4'd0;
    if (w_issue) begin
      beat_idx  = r_cnt;
      lane_mask = w_mask_raw;
    end
    if (w_wb_fire) begin
      wb_beat = r_p2_beat;
      wb_mask = r_p2_mask;
    end
    if (busy) begin
      pend_wa3 = r_wa3;
    end
  end

  // Operation latches and beat counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_last_idx <= 2'd0;
      r_rem      <= 2'd0;
      r_wa3      <= 4'd0;
    end else if (w_accept) begin
      r_cnt      <= 2'd0;
      r_last_idx <= w_last_idx;
      r_rem      <= w_vlen_eff[1:0];
      r_wa3      <= wa3;
    end else if (w_issue) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Writeback pipe: advances every cycle regardless of hold
  always_ff @(posedge clk) begin
    // NOTE: the pipe is cleared on reset and flush so no stale beat can write back.
    if (!rst_n || flush) begin
      r_p1_en   <= 1'b0;
      r_p1_beat <= 2'd0;
      r_p1_mask <= 4'd0;
      r_p1_last <= 1'b0;
      r_p2_en   <= 1'b0;
      r_p2_beat <= 2'd0;
      r_p2_mask <= 4'd0;
      r_p2_last <= 1'b0;
    end else begin
      r_p1_en   <= alu_en;
      r_p1_beat <= beat_idx;
      r_p1_mask <= lane_mask;
      r_p1_last <= w_final_issue;
      r_p2_en   <= r_p1_en;
      r_p2_beat <= r_p1_beat;
      r_p2_mask <= r_p1_mask;
      r_p2_last <= r_p1_last;
    end
  end

endmodule
